gcd_host_sequencer: RTL and testbench

- Initiator side of the GCD engine's operand-load protocol.
- Accepts operand pairs on a valid/ready interface and drives the engine's shared data bus: start asserted with A in the first cycle, B in the next cycle.
- Waits for done, captures the result and returns it on a valid/ready result interface.
- Handles zero operands locally, because the subtractive engine never terminates on zero, and bounds each engine run with a timeout counter.

---
 rtl/gcd_host_sequencer_if.sv | 29 ++
 rtl/gcd_host_sequencer.sv | 152 +++++++++++++++
 tb/tb_gcd_host_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_host_sequencer_if.sv
// Operand, result and engine-bus signals of the GCD host sequencer.
// The sequencer takes the master view; the operand source, consumer and engine take slave.
interface gcd_host_sequencer_if #(
  parameter int unsigned W = 16
);
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_gcd;
  logic         res_err;
  logic         eng_start;
  logic [W-1:0] eng_data;
  logic         eng_clear;
  logic         eng_done;
  logic [W-1:0] eng_result;

  modport master (
    input  op_valid, op_a, op_b, res_ready, eng_done, eng_result,
    output op_ready, res_valid, res_gcd, res_err, eng_start, eng_data, eng_clear
  );

  modport slave (
    output op_valid, op_a, op_b, res_ready, eng_done, eng_result,
    input  op_ready, res_valid, res_gcd, res_err, eng_start, eng_data, eng_clear
  );
endinterface

// File: rtl/gcd_host_sequencer.sv
// Initiator for the GCD engine: loads A then B on the shared bus, waits for done with a
// timeout, clears the engine and returns the result. Zero operands never reach the engine.
module gcd_host_sequencer #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TW      = 16
) (
  input logic                clk,
  input logic                rst,
  gcd_host_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StDoneLocal,
    StLoadA,
    StLoadB,
    StWait,
    StClear,
    StResp
  } state_e;

  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CntMax      = {TW{1'b1}};

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          op_ready_q, op_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_gcd_q, res_gcd_d;
  logic          res_err_q, res_err_d;
  logic          eng_start_q, eng_start_d;
  logic [W-1:0]  eng_data_q, eng_data_d;
  logic          eng_clear_q, eng_clear_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    res_gcd_d = res_gcd_q;
    res_err_d = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.op_valid && op_ready_q) begin
          a_d = bus.op_a;
          b_d = bus.op_b;
          if (bus.op_a == '0 || bus.op_b == '0) begin
            state_d = StDoneLocal;
          end else begin
            state_d = StLoadA;
          end
        end
      end
      StDoneLocal: begin
        // Both-zero falls out naturally as b_q == 0.
        res_gcd_d = (a_q == '0) ? b_q : a_q;
        res_err_d = 1'b0;
        state_d   = StResp;
      end
      StLoadA: begin
        state_d = StLoadB;
      end
      StLoadB: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + TW'(1);
        end
        // Done takes priority over a timeout landing in the same cycle.
        if (bus.eng_done) begin
          res_gcd_d = bus.eng_result;
          res_err_d = 1'b0;
          state_d   = StClear;
        end else if (cnt_q == TimeoutLast) begin
          res_gcd_d = '0;
          res_err_d = 1'b1;
          state_d   = StClear;
        end
      end
      StClear: begin
        state_d = StResp;
      end
      StResp: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so each registered value lines up with its state.
  always_comb begin
    op_ready_d  = (state_d == StIdle);
    res_valid_d = (state_d == StResp);
    eng_start_d = (state_d == StLoadA);
    eng_clear_d = (state_d == StClear);
    if (state_d == StLoadA) begin
      eng_data_d = a_d;
    end else if (state_d == StLoadB) begin
      eng_data_d = b_d;
    end else begin
      eng_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_gcd_q   <= '0;
      res_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      eng_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_gcd_q   <= res_gcd_d;
      res_err_q   <= res_err_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
      eng_clear_q <= eng_clear_d;
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_gcd   = res_gcd_q;
  assign bus.res_err   = res_err_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.eng_clear = eng_clear_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed bench for gcd_host_sequencer with a behavioural engine that answers after a
// programmable delay or hangs; expected results and latencies are hand-computed.
module tb_gcd_host_sequencer;
  localparam int unsigned W       = 16;
  localparam int unsigned TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst;

  gcd_host_sequencer_if #(.W(W)) bus ();

  gcd_host_sequencer #(
    .W      (W),
    .TIMEOUT(TIMEOUT),
    .TW     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Engine model: captures A on start, B the cycle after, then raises sticky done.
  logic [W-1:0] ea, eb;
  bit           eng_init = 0;
  bit           got_a    = 0;
  bit           running  = 0;
  bit           hang     = 0;
  int           delay    = 10;
  int           ecnt     = 0;
  int           n_start  = 0;
  int           n_clear  = 0;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  always @(negedge clk) begin
    if (!eng_init) begin
      eng_init       <= 1;
      bus.eng_done   <= 1'b0;
      bus.eng_result <= '0;
    end else if (bus.eng_clear) begin
      n_clear      <= n_clear + 1;
      bus.eng_done <= 1'b0;
      running      <= 0;
      got_a        <= 0;
    end else if (bus.eng_start) begin
      n_start      <= n_start + 1;
      ea           <= bus.eng_data;
      got_a        <= 1;
      running      <= 0;
      bus.eng_done <= 1'b0;
    end else if (got_a) begin
      eb      <= bus.eng_data;
      got_a   <= 0;
      running <= !hang;
      ecnt    <= 0;
    end else if (running) begin
      ecnt <= ecnt + 1;
      if (ecnt + 1 >= delay) begin
        bus.eng_done   <= 1'b1;
        bus.eng_result <= gcd_f(ea, eb);
        running        <= 0;
      end
    end
  end

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (!bus.op_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("op_ready_wait", 32'(bus.op_ready), 1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts negedges until res_valid is seen.
  task automatic wait_res(input string tag, input logic [W-1:0] exp_gcd, input logic exp_err,
                          input int exp_lat, input int hold);
    int   lat       = 0;
    logic saw_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.op_ready) saw_ready = 1'b1;
    end while (!bus.res_valid && lat < 200);
    check_eq({tag, "_valid"}, 32'(bus.res_valid), 1);
    check_eq({tag, "_gcd"}, 32'(bus.res_gcd), 32'(exp_gcd));
    check_eq({tag, "_err"}, 32'(bus.res_err), 32'(exp_err));
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_busy"}, 32'(saw_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(bus.res_valid), 1);
      check_eq({tag, "_hold_gcd"}, 32'(bus.res_gcd), 32'(exp_gcd));
      check_eq({tag, "_hold_opready"}, 32'(bus.op_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(bus.res_valid), 0);
  endtask

  int s0, c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.res_ready = 1'b0;
    #12;
    check_eq("rst_op_ready", 32'(bus.op_ready), 0);
    check_eq("rst_res_valid", 32'(bus.res_valid), 0);
    check_eq("rst_res_gcd", 32'(bus.res_gcd), 0);
    check_eq("rst_res_err", 32'(bus.res_err), 0);
    check_eq("rst_eng_start", 32'(bus.eng_start), 0);
    check_eq("rst_eng_data", 32'(bus.eng_data), 0);
    check_eq("rst_eng_clear", 32'(bus.eng_clear), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 48,18 with a 10-cycle engine: 4 + 10 cycles to res_valid.
    delay = 10; hang = 0;
    s0 = n_start; c0 = n_clear;
    send_op(16'd48, 16'd18);
    wait_res("g48_18", 16'd6, 1'b0, 14, 0);
    check_eq("g48_18_eng_a", 32'(ea), 48);
    check_eq("g48_18_eng_b", 32'(eb), 18);
    check_eq("g48_18_starts", n_start - s0, 1);
    check_eq("g48_18_clears", n_clear - c0, 1);

    // Zero operands are resolved locally in 2 cycles.
    s0 = n_start; c0 = n_clear;
    send_op(16'd0, 16'd35);
    wait_res("z0_35", 16'd35, 1'b0, 2, 0);
    send_op(16'd0, 16'd0);
    wait_res("z0_0", 16'd0, 1'b0, 2, 0);
    check_eq("zero_starts", n_start - s0, 0);
    check_eq("zero_clears", n_clear - c0, 0);

    // Back-pressure: a pending zero pair must wait for the result handshake.
    delay = 3;
    s0 = n_start;
    send_op(16'd21, 16'd14);
    bus.op_a = 16'd0; bus.op_b = 16'd5; bus.op_valid = 1'b1;
    wait_res("bp21_14", 16'd7, 1'b0, 7, 15);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    wait_res("bp_next", 16'd5, 1'b0, 2, 0);
    check_eq("bp_starts", n_start - s0, 1);

    // Hung engine: 20 WAIT cycles then abort.
    hang = 1;
    c0 = n_clear;
    send_op(16'd40, 16'd24);
    wait_res("tmo", 16'd0, 1'b1, 24, 0);
    check_eq("tmo_clears", n_clear - c0, 1);

    // Asynchronous reset during WAIT; res_err still holds 1 from the aborted run.
    hang = 0; delay = 30;
    c0 = n_clear;
    send_op(16'd100, 16'd75);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_op_ready", 32'(bus.op_ready), 0);
    check_eq("mid_res_valid", 32'(bus.res_valid), 0);
    check_eq("mid_res_gcd", 32'(bus.res_gcd), 0);
    check_eq("mid_res_err", 32'(bus.res_err), 0);
    check_eq("mid_eng_start", 32'(bus.eng_start), 0);
    check_eq("mid_eng_data", 32'(bus.eng_data), 0);
    check_eq("mid_eng_clear", 32'(bus.eng_clear), 0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_no_clear", n_clear - c0, 0);
    delay = 4;
    send_op(16'd9, 16'd6);
    wait_res("g9_6", 16'd3, 1'b0, 8, 0);

    // Back-to-back pairs.
    delay = 2;
    send_op(16'd12, 16'd8);
    wait_res("b2b_12_8", 16'd4, 1'b0, 6, 0);
    send_op(16'd17, 16'd5);
    wait_res("b2b_17_5", 16'd1, 1'b0, 6, 0);
    send_op(16'hFFFF, 16'd1);
    wait_res("b2b_max_1", 16'd1, 1'b0, 6, 0);
    check_eq("b2b_max_eng_a", 32'(ea), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
